// File: rtl/uart_rx_core_if.sv
// Byte-side handshake of the UART receiver: one-cycle done pulse, byte and error flags.
// Optional parity_err member exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_core_if;
    logic       rx_done_tick;
    logic [7:0] dout;
    logic       frame_err;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    // master: the receiver that produces bytes; slave: the command parser that consumes them
    modport master (
        output rx_done_tick,
        output dout,
        output frame_err
`ifdef UART_RX_PARITY_EN
        ,
        output parity_err
`endif
    );

    modport slave (
        input rx_done_tick,
        input dout,
        input frame_err
`ifdef UART_RX_PARITY_EN
        ,
        input parity_err
`endif
    );
endinterface

// File: rtl/uart_rx_core.sv
// 16x-oversampling UART receiver, start + DBIT data (LSB first) [+ even parity] + stop.
// Define UART_RX_PARITY_EN to add the parity bit, the parity state and parity_err.
module uart_rx_core #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           s_tick,
    input  logic           rx,
    uart_rx_core_if.master rx_if
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    localparam logic [5:0] MID_START = 6'd7;
    localparam logic [5:0] BIT_LAST  = 6'd15;
    localparam logic [5:0] STOP_LAST = 6'(SB_TICK - 1);
    localparam logic [2:0] N_LAST    = 3'(DBIT - 1);
    localparam int         ALIGN     = 8 - DBIT;

    state_t     state;
    logic [5:0] s_cnt;
    logic [2:0] n_cnt;
    logic [7:0] b_reg;
    logic       rx_meta;
    logic       rx_s;
`ifdef UART_RX_PARITY_EN
    logic       par_bit;
`endif

    // Both flops reset to the idle line level so reset release never looks like a start edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make rx_meta->rx_s a true two-stage pipeline.
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state              <= IDLE;
            s_cnt              <= '0;
            n_cnt              <= '0;
            b_reg              <= '0;
            rx_if.dout         <= '0;
            rx_if.rx_done_tick <= 1'b0;
            rx_if.frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            rx_if.parity_err   <= 1'b0;
            par_bit            <= 1'b0;
`endif
        end else begin
            // Pulses default low so each lasts exactly one clk.
            rx_if.rx_done_tick <= 1'b0;
            rx_if.frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            rx_if.parity_err   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    // A coincident s_tick is deliberately not counted here.
                    if (!rx_s) begin
                        state <= START;
                        s_cnt <= '0;
                    end
                end

                START: begin
                    if (s_tick) begin
                        if (s_cnt == MID_START) begin
                            if (!rx_s) begin
                                state <= DATA;
                                s_cnt <= '0;
                                n_cnt <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            s_cnt <= s_cnt + 6'd1;
                        end
                    end
                end

                DATA: begin
                    if (s_tick) begin
                        if (s_cnt == BIT_LAST) begin
                            s_cnt <= '0;
                            b_reg <= {rx_s, b_reg[7:1]};
                            n_cnt <= n_cnt + 3'd1;
                            if (n_cnt == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end
                        end else begin
                            s_cnt <= s_cnt + 6'd1;
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (s_tick) begin
                        if (s_cnt == BIT_LAST) begin
                            par_bit <= rx_s;
                            s_cnt   <= '0;
                            state   <= STOP;
                        end else begin
                            s_cnt <= s_cnt + 6'd1;
                        end
                    end
                end
`endif

                STOP: begin
                    if (s_tick) begin
                        if (s_cnt == STOP_LAST) begin
                            // The byte is delivered even on a framing error; the parser decides.
                            rx_if.dout         <= b_reg >> ALIGN;
                            rx_if.rx_done_tick <= 1'b1;
                            rx_if.frame_err    <= ~rx_s;
`ifdef UART_RX_PARITY_EN
                            rx_if.parity_err   <= (^(b_reg >> ALIGN)) ^ par_bit;
`endif
                            state              <= IDLE;
                        end else begin
                            s_cnt <= s_cnt + 6'd1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Serial-to-byte UART receiver that feeds the ASCII command parser ahead of the ALU. It oversamples the asynchronous `rx` line using a 16× baud tick and reassembles 8N1 frames. For each completed frame it presents one byte on `dout` with a single-cycle `rx_done_tick`, which is the exact handshake the parser consumes. Framing errors are flagged. Parity checking is optional.

## Interface
- `DBIT`, default 8: data bits per frame, LSB first; legal range 5–8.
- `SB_TICK`, default 16: s_ticks in the stop period; 16 = 1 stop bit, 24 = 1.5, 32 = 2.
- `clk` input 1: system clock; all logic on the rising edge.
- `reset` input 1: asynchronous, active-low reset (asserted when 0). Deassertion is synchronous to `clk` at system level.
- `s_tick` input 1: one-`clk` pulse at 16× baud, from the shared baud generator.
- `rx` input 1: asynchronous serial line; idles high.
- `rx_done_tick` output 1: one-`clk` pulse; `dout` is valid from this cycle on.
- `dout` output 8: last received byte. When `DBIT`<8, data occupies `dout[DBIT-1:0]` and the upper bits are 0.
- `frame_err` output 1: one-`clk` pulse, coincident with `rx_done_tick`, when the sampled stop bit was 0.
- `parity_err` output 1: present only with `UART_RX_PARITY_EN`; pulses with `rx_done_tick` on an even-parity mismatch.

## Operation
- **Input synchronizer.** `rx` passes through a 2-flop synchronizer; the FSM sees only the synchronized `rx_s`. Both flops reset to 1.
- **Registers.** `state`; `s_cnt` (4 bits for the bit-time counter, 6 bits for the stop counter up to `SB_TICK`-1); `n_cnt` (3 bits); `b_reg` (8-bit shift register).
- **idle.** On `rx_s`==0, go to start and clear `s_cnt`. `s_tick` is not required to leave idle.
- **start.** Count `s_tick`s. When `s_cnt`==7 (mid start bit), re-sample:
  - `rx_s`==0: go to data, clear `s_cnt` and `n_cnt`.
  - `rx_s`==1: glitch; return to idle with no outputs.
- **data.** On the `s_tick` where `s_cnt`==15, shift `b_reg` right with `rx_s` entering the MSB, clear `s_cnt`, and increment `n_cnt`. When `n_cnt`==`DBIT`-1 at that same tick, go to parity (macro on) or stop (macro off).
- **parity.** On `s_cnt`==15, capture the parity bit and go to stop.
- **stop.** On the `s_tick` where `s_cnt`==`SB_TICK`-1:
  - Register `dout` = `b_reg` right-aligned, i.e. shifted right by 8-`DBIT`.
  - Pulse `rx_done_tick`.
  - Pulse `frame_err` if `rx_s`==0.
  - Return to idle.
- **Byte delivery.** `dout` updates even when `frame_err` is set; the parser decides whether to discard it.
- **Output stability.** `dout` holds its value until the next completed frame.
- **No backpressure.** There is no flow control. A new byte overwrites `dout` regardless of whether the consumer read the previous one.
- **Line stuck low.** If `rx_s` is still 0 when stop completes (break condition), the FSM returns to idle and immediately re-enters start. A break therefore produces repeated `frame_err` frames of value 0x00, one per frame time.

## Timing
- **Reset.** While `reset`==0:
  - state = idle; `s_cnt`, `n_cnt`, `b_reg` = 0.
  - `dout` = 0x00; `rx_done_tick` = 0; `frame_err` = 0; `parity_err` = 0.
  - Synchronizer flops = 1.
- **Reset mid-frame.** Asserting reset during a frame aborts it with no pulse. After reset releases, the FSM waits for the next falling edge.
- **Synchronizer latency.** 2 `clk` from an `rx` edge to `rx_s`.
- **Output registration.** `rx_done_tick`, `frame_err`, `parity_err`, and `dout` are registered. They change on the `clk` edge that follows the final stop-period `s_tick`.
- **Pulse width.** Each pulse lasts exactly 1 `clk`.
- **Frame latency (8N1, `SB_TICK`=16).** 8 + 16·8 + 16 = 152 `s_tick`s from start-bit detection to `rx_done_tick`, plus 2–3 `clk` of synchronization and registration.
- **Back-to-back frames.** A start bit immediately following the stop period is accepted with no idle gap. The falling edge is detected in idle on the cycle after the return.
- **Tick coincidence.** An `s_tick` coinciding with the idle→start transition is not counted.

## Configuration
- **Macro.** `UART_RX_PARITY_EN`.
- **Defined.**
  - The frame is start + `DBIT` data + 1 even-parity bit + stop.
  - The parity state is compiled in, and the `parity_err` port exists.
  - Parity is checked as XOR(data bits, parity bit); the check fails when the result is 1.
- **Undefined.** The parity state and the `parity_err` port are absent, and data goes straight to stop.

## Test plan
- **Single byte.** 8N1 frame 0x66 ('f'), 16 `s_tick`s per bit, 1 tick per 10 `clk` → exactly one `rx_done_tick`, `dout`=0x66, `frame_err`=0.
- **Start glitch.** `rx` low for 4 `s_tick`s, then high → no `rx_done_tick`, state back to idle, `dout` unchanged.
- **Framing error.** Frame 0x31 with stop bit driven 0 → `rx_done_tick` and `frame_err` pulse in the same cycle, `dout`=0x31.
- **Back-to-back frames.** Frames '1','2','f','d' (0x31, 0x32, 0x66, 0x64) with no idle gap → four pulses, with `dout` matching each byte in order.
- **Reset mid-frame.** `reset`=0 during data bit 3, released, then frame 0xA5 sent → all outputs 0 during reset, a single pulse afterwards with `dout`=0xA5.
- **Parity (`UART_RX_PARITY_EN`).** Frame 0x07 with parity bit 1 → `parity_err`=0. Same frame with parity bit 0 → `parity_err` pulses with `rx_done_tick`.
